// File: rtl/muldiv_wb_unit.sv
// Iterative RV32M multiply/divide unit with a registered one-cycle register-file writeback.
// Optional MULDIV_FLUSH_EN adds a flush input that abandons the in-flight op.
module muldiv_wb_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  input  logic [ADDRESS_WIDTH-1:0] dest,
`ifdef MULDIV_FLUSH_EN
  input  logic                     flush,
`endif
  output logic                     busy,
  output logic                     wb_en,
  output logic [ADDRESS_WIDTH-1:0] wb_dest,
  output logic [DATA_WIDTH-1:0]    wb_data
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  logic flush_w;
`ifdef MULDIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
  logic [W-1:0]           mb_q, mb_d;
  logic                   neg_q, neg_d;
  logic [2*W-1:0]         p_q, p_d;
  logic                   busy_q, busy_d;
  logic                   wb_en_q, wb_en_d;
  logic [ADDRESS_WIDTH-1:0] wb_dest_q, wb_dest_d;
  logic [W-1:0]           wb_data_q, wb_data_d;

  // Operand decode at accept time: magnitudes plus the sign to apply to the final result
  logic         a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg    = a_signed & op_a[W-1];
    b_neg    = b_signed & op_b[W-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    unique case (funct3[2:1])
      2'b10:   res_neg = (a_neg ^ b_neg) & (op_b != '0); // divide by zero keeps all-ones
      2'b11:   res_neg = a_neg;
      default: res_neg = a_neg ^ b_neg;
    endcase
  end

  // p_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [2*W:0]   div_sh;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   q_raw, r_raw, quot_fix, rem_fix, result;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, mb_q} : '0);
    mul_next = {mul_sum, p_q[W-1:1]};
    div_sh   = {p_q, 1'b0};
    div_diff = div_sh[2*W:W] - {1'b0, mb_q};
    div_next = div_diff[W] ? div_sh[2*W-1:0] : {div_diff[W-1:0], div_sh[W-1:1], 1'b1};

    prod_fix = neg_q ? -p_q : p_q;
    q_raw    = p_q[W-1:0];
    r_raw    = p_q[2*W-1:W];
    quot_fix = neg_q ? -q_raw : q_raw;
    rem_fix  = neg_q ? -r_raw : r_raw;
    unique case (funct3_q)
      3'd0:             result = prod_fix[W-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[2*W-1:W];
      3'd4, 3'd5:       result = quot_fix;
      default:          result = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    funct3_d  = funct3_q;
    dest_d    = dest_q;
    mb_d      = mb_q;
    neg_d     = neg_q;
    p_d       = p_q;
    busy_d    = busy_q;
    wb_en_d   = 1'b0;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush_w) begin
          funct3_d = funct3;
          dest_d   = dest;
          mb_d     = b_mag;
          neg_d    = res_neg;
          p_d      = {{W{1'b0}}, a_mag};
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (count_q == CntW'(W)) begin
          wb_data_d = result;
          wb_dest_d = dest_q;
          wb_en_d   = (dest_q != '0);
          state_d   = StDone;
        end else begin
          p_d     = funct3_q[2] ? div_next : mul_next;
          count_d = count_q + CntW'(1);
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_w && (state_q != StIdle)) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      wb_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      funct3_q  <= '0;
      dest_q    <= '0;
      mb_q      <= '0;
      neg_q     <= 1'b0;
      p_q       <= '0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      funct3_q  <= funct3_d;
      dest_q    <= dest_d;
      mb_q      <= mb_d;
      neg_q     <= neg_d;
      p_q       <= p_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy    = busy_q;
  assign wb_en   = wb_en_q;
  assign wb_dest = wb_dest_q;
  assign wb_data = wb_data_q;

endmodule
